// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the 7-segment scan controller
// Purpose: active-high segment shapes {g,f,e,d,c,b,a} for hex digits 0-F, the
//          blank pattern, and a constant clog2 helper for sizing the digit index.
// Ports:   none (package).
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h7C;
   localparam logic [6:0] SEG_C     = 7'h39;
   localparam logic [6:0] SEG_D     = 7'h5E;
   localparam logic [6:0] SEG_E     = 7'h79;
   localparam logic [6:0] SEG_F     = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Smallest w with 2**w >= n; used only on elaboration-time constants.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-high 7-segment pattern
// Purpose: maps 0-F to standard digit shapes (b and d lowercase).
// Ports:   nibble - 4-bit hex digit in
//          seg    - segments {g,f,e,d,c,b,a}, active-high, seg[0]=a
module hex_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         4'hF: seg = SEG_F;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment display scan driver
// Purpose: advances one digit per rising edge of the divided slow clock level,
//          displays a per-frame snapshot of value with optional leading-zero
//          blanking and per-digit decimal points; registered outputs.
// Ports:   clk      - system clock
//          rst      - synchronous active-high reset
//          slow_clk - divided clock level, same clk domain
//          value    - 4*DIGITS hex value, nibble k drives digit k
//          dp_mask  - decimal point enable per digit
//          blank_lz - 1 = blank leading zero digits (sampled live)
//          an       - digit enables, one-hot when active
//          seg      - segments {g,f,e,d,c,b,a}
//          dp       - decimal point
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter bit ACTIVE_LOW = 1'b1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  slow_clk,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_mask,
   input  logic                  blank_lz,
   output logic [DIGITS-1:0]     an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int               IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(DIGITS - 1);
   localparam logic             POL   = ACTIVE_LOW;

   logic                  slow_q;
   logic                  tick;
   logic                  armed;
   logic [IDX_W-1:0]      idx;
   logic [4*DIGITS-1:0]   snap_val;
   logic [DIGITS-1:0]     snap_dp;

   // slow_q resets high so a level already high at reset release is not an edge.
   assign tick = slow_clk & ~slow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         slow_q   <= 1'b1;
         idx      <= '0;
         snap_val <= '0;
         snap_dp  <= '0;
         armed    <= 1'b0;
      end else begin
         slow_q <= slow_clk;
         if (tick) begin
            armed <= 1'b1;
            if (idx == LAST) begin
               // Snapshot on wrap so every frame is drawn from one value.
               idx      <= '0;
               snap_val <= value;
               snap_dp  <= dp_mask;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

   logic [3:0]        cur_nib;
   logic [DIGITS-1:0] an_hi;
   logic              dp_hi;
   logic              upper_nz;
   logic              blank;
   logic [6:0]        hex_seg;
   logic [6:0]        seg_hi;

   always_comb begin
      cur_nib  = 4'h0;
      an_hi    = '0;
      dp_hi    = 1'b0;
      upper_nz = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (IDX_W'(k) == idx) begin
            cur_nib  = snap_val[4*k +: 4];
            an_hi[k] = 1'b1;
            dp_hi    = snap_dp[k];
         end
         // Any nonzero nibble at or above the current digit makes it significant.
         if ((IDX_W'(k) >= idx) && (snap_val[4*k +: 4] != 4'h0)) begin
            upper_nz = 1'b1;
         end
      end
      blank  = blank_lz && (idx != '0) && !upper_nz;
      seg_hi = blank ? SEG_BLANK : hex_seg;
   end

   hex_to_seg7 u_hex (
      .nibble (cur_nib),
      .seg    (hex_seg)
   );

   // Anode stays asserted on blanked digits to keep the duty cycle constant.
   always_ff @(posedge clk) begin
      if (rst || !armed) begin
         an  <= {DIGITS{POL}};
         seg <= {7{POL}};
         dp  <= POL;
      end else begin
         an  <= an_hi ^ {DIGITS{POL}};
         seg <= seg_hi ^ {7{POL}};
         dp  <= dp_hi ^ POL;
      end
   end

endmodule
